// File: rtl/axils_rd_ch.sv
// AXI4-Lite slave read channel: decodes AR, strobes a local read port, returns data on R.
// Optional local-response timeout enabled by defining AXILS_RD_TIMEOUT_EN.
module axils_rd_ch #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [31:0] ADDR_SPAN      = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [31:0] ARADDR,
    input  logic [2:0]  ARPROT,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        USR_REN,
    output logic [31:0] USR_RADDR,
    input  logic [31:0] USR_RDATA,
    input  logic        USR_RVALID,
    input  logic        USR_RERR
);

    typedef enum logic [1:0] {IDLE, LOCAL_WAIT, RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t      state, state_d;
    logic        arready_d, rvalid_d, usr_ren_d;
    logic [31:0] rdata_d, usr_raddr_d;
    logic [1:0]  rresp_d;
    logic [31:0] offset;
    logic        in_range;
    logic        unused_ok;

`ifdef AXILS_RD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt, cnt_d;
    assign unused_ok = ^ARPROT;
`else
    assign unused_ok = ^{ARPROT, 32'(TIMEOUT_CYCLES)};
`endif

    // Window check without wrap: below-base addresses are rejected before the span test
    assign offset   = ARADDR - ADDR_BASE;
    assign in_range = (ARADDR >= ADDR_BASE) && (offset < ADDR_SPAN);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RDATA     <= '0;
            RRESP     <= RESP_OKAY;
            USR_REN   <= 1'b0;
            USR_RADDR <= '0;
`ifdef AXILS_RD_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_d;
            ARREADY   <= arready_d;
            RVALID    <= rvalid_d;
            RDATA     <= rdata_d;
            RRESP     <= rresp_d;
            USR_REN   <= usr_ren_d;
            USR_RADDR <= usr_raddr_d;
`ifdef AXILS_RD_TIMEOUT_EN
            cnt       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state;
        arready_d   = ARREADY;
        rvalid_d    = RVALID;
        rdata_d     = RDATA;
        rresp_d     = RRESP;
        usr_ren_d   = 1'b0;
        usr_raddr_d = USR_RADDR;
`ifdef AXILS_RD_TIMEOUT_EN
        cnt_d       = cnt;
`endif
        unique case (state)
            IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && ARREADY) begin
                    arready_d = 1'b0;
                    if (in_range) begin
                        usr_raddr_d = offset & ~32'h3;
                        usr_ren_d   = 1'b1;
                        state_d     = LOCAL_WAIT;
`ifdef AXILS_RD_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        rdata_d  = '0;
                        rresp_d  = RESP_DECERR;
                        rvalid_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            LOCAL_WAIT: begin
                // A local response in the final timeout cycle still wins
                if (USR_RVALID) begin
                    rdata_d  = USR_RDATA;
                    rresp_d  = USR_RERR ? RESP_SLVERR : RESP_OKAY;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end
`ifdef AXILS_RD_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (RVALID && RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
